// File: rtl/csa_pkg.sv
// Shared constants and tree-shape helpers for the carry-save lane accumulator.
package csa_pkg;

   localparam int ACC_GUARD      = 16;
   localparam int N_DEF          = 8;
   localparam int WIDTH_DEF      = 16;
   localparam int PIPE_DEPTH_DEF = 2;
   localparam int OUT_WIDTH_DEF  = 32;

   function automatic int accWidth(input int width, input int n);
      return width + $clog2(n) + ACC_GUARD;
   endfunction

   // Operands entering tree level lvl: every full triple becomes a pair, leftovers pass through.
   function automatic int opsAt(input int n, input int lvl);
      int m;
      m = n;
      for (int i = 0; i < lvl; i++) m = 2 * (m / 3) + m % 3;
      return m;
   endfunction

   function automatic int treeLevels(input int n);
      int m;
      int l;
      m = n;
      l = 0;
      while (m > 2) begin
         m = 2 * (m / 3) + m % 3;
         l++;
      end
      return l;
   endfunction

endpackage

// File: rtl/csa_3to2.sv
// Combinational 3:2 compressor: three operands in, sum and left-shifted carry out.
module csa_3to2 #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   assign sum_o   = a_i ^ b_i ^ c_i;
   assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) |
                     (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_acc_pipe.sv
// Pipelined carry-save lane reducer with group accumulator and valid/ready output.
// Define CSA_SAT_EN to clamp out-of-range results instead of truncating them.
module csa_acc_pipe
   import csa_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int WIDTH      = WIDTH_DEF,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
   parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0][WIDTH-1:0] in,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic                    signed_mode,
   output logic                    in_ready,
   output logic [OUT_WIDTH-1:0]    out_sum,
   output logic                    out_ovf,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int ACC_W  = accWidth(WIDTH, N);
   localparam int LEVELS = treeLevels(N);
   localparam int XW     = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

   logic                  stall;
   logic                  inFirst_q, grpMode_q, laneMode;
   logic [ACC_W-1:0]      lanes [N];
   logic [PIPE_DEPTH-1:0] vld_q, last_q, mode_q;
   logic [PIPE_DEPTH:0]   vldChain, lastChain, modeChain;
   logic [ACC_W-1:0]      sum_q, acc_q, total;
   logic                  sumVld_q, sumLast_q, sumMode_q, accFirst_q;
   logic [XW-1:0]         wide;
   logic                  fits;
   logic [OUT_WIDTH-1:0]  res_d, outSum_q;
   logic                  outValid_q, outOvf_q;

   assign stall     = outValid_q && !out_ready;
   assign in_ready  = !stall;
   assign laneMode  = inFirst_q ? signed_mode : grpMode_q;
   assign vldChain  = {vld_q, in_valid};
   assign lastChain = {last_q, in_last};
   assign modeChain = {mode_q, laneMode};

   always_comb begin
      for (int i = 0; i < N; i++)
         lanes[i] = {{(ACC_W-WIDTH){laneMode & in[i][WIDTH-1]}}, in[i]};
   end

   // The group's signedness is latched from its first beat and reused for the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inFirst_q <= 1'b1;
         grpMode_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         inFirst_q <= in_last;
         grpMode_q <= laneMode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         last_q <= '0;
         mode_q <= '0;
      end else if (!stall) begin
         vld_q  <= vldChain[PIPE_DEPTH-1:0];
         last_q <= lastChain[PIPE_DEPTH-1:0];
         mode_q <= modeChain[PIPE_DEPTH-1:0];
      end
   end

   // Tree levels are spread evenly over the register stages; a stage may own no level.
   for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stg
      localparam int LO = s * LEVELS / PIPE_DEPTH;
      localparam int HI = (s + 1) * LEVELS / PIPE_DEPTH;
      logic [ACC_W-1:0] din   [N];
      logic [ACC_W-1:0] dout  [N];
      logic [ACC_W-1:0] ops_q [N];

      if (s == 0) begin : g_src_in
         assign din = lanes;
      end else begin : g_src_reg
         assign din = g_stg[s-1].ops_q;
      end

      for (genvar l = LO; l < HI; l++) begin : g_lvl
         localparam int M = opsAt(N, l);
         localparam int C = M / 3;
         localparam int R = M % 3;
         logic [ACC_W-1:0] src [N];
         logic [ACC_W-1:0] dst [N];

         if (l == LO) begin : g_first
            assign src = din;
         end else begin : g_chain
            assign src = g_lvl[l-1].dst;
         end

         for (genvar j = 0; j < C; j++) begin : g_csa
            csa_3to2 #(.W(ACC_W)) u_csa (
               .a_i     (src[3*j]),
               .b_i     (src[3*j+1]),
               .c_i     (src[3*j+2]),
               .sum_o   (dst[2*j]),
               .carry_o (dst[2*j+1])
            );
         end
         for (genvar j = 0; j < R; j++) begin : g_pass
            assign dst[2*C+j] = src[3*C+j];
         end
         for (genvar j = 2*C+R; j < N; j++) begin : g_fill
            assign dst[j] = '0;
         end
      end

      if (HI > LO) begin : g_out_tree
         assign dout = g_lvl[HI-1].dst;
      end else begin : g_out_pass
         assign dout = din;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      ops_q <= '{default: '0};
         else if (!stall) ops_q <= dout;
      end
   end

   // Final carry-propagate add gets its own stage so the accumulator add stays short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= '0;
         sumVld_q  <= 1'b0;
         sumLast_q <= 1'b0;
         sumMode_q <= 1'b0;
      end else if (!stall) begin
         sum_q     <= g_stg[PIPE_DEPTH-1].ops_q[0] + g_stg[PIPE_DEPTH-1].ops_q[1];
         sumVld_q  <= vldChain[PIPE_DEPTH];
         sumLast_q <= lastChain[PIPE_DEPTH];
         sumMode_q <= modeChain[PIPE_DEPTH];
      end
   end

   assign total = (accFirst_q ? '0 : acc_q) + sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         accFirst_q <= 1'b1;
      end else if (!stall && sumVld_q) begin
         acc_q      <= total;
         accFirst_q <= sumLast_q;
      end
   end

   always_comb begin
      wide = {{(XW-ACC_W){sumMode_q & total[ACC_W-1]}}, total};
      if (sumMode_q) fits = (wide[XW-1:OUT_WIDTH-1] == {(XW-OUT_WIDTH+1){wide[XW-1]}});
      else           fits = (wide[XW-1:OUT_WIDTH] == '0);
      res_d = wide[OUT_WIDTH-1:0];
`ifdef CSA_SAT_EN
      if (!fits) begin
         if (!sumMode_q)      res_d = '1;
         else if (wide[XW-1]) res_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         else                 res_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outSum_q   <= '0;
         outOvf_q   <= 1'b0;
      end else if (!stall) begin
         outValid_q <= sumVld_q && sumLast_q;
         if (sumVld_q && sumLast_q) begin
            outSum_q <= res_d;
            outOvf_q <= !fits;
         end
      end
   end

   assign out_sum   = outSum_q;
   assign out_ovf   = outOvf_q;
   assign out_valid = outValid_q;

endmodule

// File: tb/tb_csa_acc_pipe.sv
// Randomized bench for csa_acc_pipe: two instances (32-bit and 16-bit results) share stimulus
// and are scored against an arithmetic reference of each accumulation group.
module tb_csa_acc_pipe;

   localparam int N = 8;
   localparam int W = 16;
`ifdef CSA_SAT_EN
   localparam logic [15:0] U16_SUM = 16'hFFFF;
   localparam logic [15:0] S16_SUM = 16'h8000;
`else
   localparam logic [15:0] U16_SUM = 16'hFFF8;
   localparam logic [15:0] S16_SUM = 16'h0000;
`endif

   typedef struct {
      longint sum32;
      bit     ovf32;
      longint sum16;
      bit     ovf16;
   } result_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0][W-1:0] inLanes;
   logic                in_valid, in_last, signed_mode, out_ready;
   logic                inReady32, outOvf32, outValid32;
   logic                inReady16, outOvf16, outValid16;
   logic [31:0]         outSum32;
   logic [15:0]         outSum16;

   result_t expQ [$];
   int      total = 0;
   int      bad = 0;
   int      groupsSent = 0;
   bit      sawStall = 1'b0;
   bit      prevStall = 1'b0;

   always #5 clk = ~clk;

   csa_acc_pipe dut32 (
      .clk(clk), .rst_n(rst_n), .in(inLanes), .in_valid(in_valid), .in_last(in_last),
      .signed_mode(signed_mode), .in_ready(inReady32), .out_sum(outSum32),
      .out_ovf(outOvf32), .out_valid(outValid32), .out_ready(out_ready)
   );

   csa_acc_pipe #(.OUT_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in(inLanes), .in_valid(in_valid), .in_last(in_last),
      .signed_mode(signed_mode), .in_ready(inReady16), .out_sum(outSum16),
      .out_ovf(outOvf16), .out_valid(outValid16), .out_ready(out_ready)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference: clamp or wrap the exact group value into ow bits.
   function automatic void modelResult(input longint v, input bit sgn, input int ow,
                                       output longint s, output bit ovf);
      longint m, lo, hi, c;
      m   = longint'(1) << ow;
      lo  = sgn ? -(m / 2) : 0;
      hi  = sgn ? (m / 2 - 1) : (m - 1);
      ovf = (v < lo) || (v > hi);
`ifdef CSA_SAT_EN
      c = (v < lo) ? lo : ((v > hi) ? hi : v);
`else
      c = v;
`endif
      s = c & (m - 1);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat from posedge+1 and hold it until an edge accepts it.
   task automatic applyStimulus(input logic [N-1:0][W-1:0] lanes, input bit last, input bit mode);
      int waitCycles = 0;
      inLanes     = lanes;
      in_valid    = 1'b1;
      in_last     = last;
      signed_mode = mode;
      @(negedge clk);
      while (!inReady32 && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      if (waitCycles >= 100) checkOutput("acceptTimeout", waitCycles, 0);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      signed_mode = 1'($urandom);
      inLanes     = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_valid32"}, outValid32, 0);
      checkOutput({tag, "_sum32"}, outSum32, 0);
      checkOutput({tag, "_ovf32"}, outOvf32, 0);
      checkOutput({tag, "_ready32"}, inReady32, 1);
      checkOutput({tag, "_valid16"}, outValid16, 0);
      checkOutput({tag, "_sum16"}, outSum16, 0);
      checkOutput({tag, "_ovf16"}, outOvf16, 0);
      checkOutput({tag, "_ready16"}, inReady16, 1);
   endtask

   task automatic drain();
      int cycles = 0;
      while (expQ.size() != 0 && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("drainLeft", expQ.size(), 0);
      idle(2);
   endtask

   task automatic randomGroups(input int count);
      for (int g = 0; g < count; g++) begin
         int     beats = $urandom_range(1, 4);
         bit     mode = 1'($urandom_range(0, 1));
         longint acc = 0;
         for (int b = 0; b < beats; b++) begin
            logic [N-1:0][W-1:0] lanes;
            result_t             r;
            int                  pat = $urandom_range(0, 5);
            for (int i = 0; i < N; i++)
               lanes[i] = (pat == 0) ? 16'hFFFF : (pat == 1) ? 16'h8000 :
                          (pat == 2) ? 16'h7FFF : 16'($urandom);
            for (int i = 0; i < N; i++)
               acc += (mode && lanes[i][W-1]) ? longint'(lanes[i]) - 65536 : longint'(lanes[i]);
            if (b == beats - 1) begin
               modelResult(acc, mode, 32, r.sum32, r.ovf32);
               modelResult(acc, mode, 16, r.sum16, r.ovf16);
               expQ.push_back(r);
               groupsSent++;
            end
            applyStimulus(lanes, b == beats - 1, (b == 0) ? mode : 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
   endtask

   task automatic applyBackpressure();
      for (int k = 0; k < 2; k++) begin
         int guard = 0;
         while (groupsSent < ((k == 0) ? 10 : 30) && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         out_ready = 1'b0;
         idle(5);
         out_ready = 1'b1;
      end
   endtask

   // Scoreboard: every cycle with out_valid must show the oldest outstanding group.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("inReady32", inReady32, !(outValid32 && !out_ready));
         checkOutput("inReady16", inReady16, !(outValid32 && !out_ready));
         if (!inReady32) sawStall = 1'b1;
         if (prevStall) checkOutput("holdValid", outValid32, 1);
         if (outValid32) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedOut", 1, 0);
            end else begin
               checkOutput("sum32", outSum32, expQ[0].sum32);
               checkOutput("ovf32", outOvf32, expQ[0].ovf32);
               checkOutput("valid16", outValid16, 1);
               checkOutput("sum16", outSum16, expQ[0].sum16);
               checkOutput("ovf16", outOvf16, expQ[0].ovf16);
               if (out_ready) void'(expQ.pop_front());
            end
         end
         prevStall = outValid32 && !out_ready;
      end else begin
         prevStall = 1'b0;
      end
   end

   initial begin
      logic [N-1:0][W-1:0] lanes;
      result_t             r;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      signed_mode = 1'b0;
      inLanes     = '0;
      out_ready   = 1'b1;
      repeat (2) @(negedge clk);
      checkReset("rst0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      $display("[TB] unsigned single beat, all lanes 0xFFFF");
      for (int i = 0; i < N; i++) lanes[i] = 16'hFFFF;
      r = '{524280, 1'b0, longint'(U16_SUM), 1'b1};
      expQ.push_back(r);
      applyStimulus(lanes, 1'b1, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("latK%0d", c), outValid32, (c == 3));
      end
      checkOutput("uSum32", outSum32, 524280);
      checkOutput("uOvf32", outOvf32, 0);
      checkOutput("uSum16", outSum16, U16_SUM);
      checkOutput("uOvf16", outOvf16, 1);
      drain();

      $display("[TB] signed three beats, all lanes 0x8000");
      for (int i = 0; i < N; i++) lanes[i] = 16'h8000;
      r = '{64'hFFF40000, 1'b0, longint'(S16_SUM), 1'b1};
      expQ.push_back(r);
      for (int b = 0; b < 3; b++) applyStimulus(lanes, b == 2, 1'b1);
      drain();

      $display("[TB] random groups with backpressure");
      fork
         randomGroups(50);
         applyBackpressure();
      join
      drain();
      checkOutput("sawStall", sawStall, 1);

      $display("[TB] reset in the middle of a group");
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < N; i++) lanes[i] = 16'($urandom);
         applyStimulus(lanes, 1'b0, 1'b0);
      end
      idle(1);
      rst_n = 1'b0;
      @(negedge clk);
      checkReset("rstMid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) lanes[i] = 16'h0001;
      r = '{8, 1'b0, 8, 1'b0};
      expQ.push_back(r);
      applyStimulus(lanes, 1'b1, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
